// File: rtl/dma_apb_bridge.sv
// APB3 slave that turns APB transfers into single-cycle wr_en/rd_en strobes for
// the DMA register block, adding read wait states and decode error responses.
module dma_apb_bridge #(
    parameter int unsigned         ADDR_W    = 32,
    parameter int unsigned         DATA_W    = 32,
    parameter logic [ADDR_W-1:0]   ADDR_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]   ADDR_SIZE = 32'h0000_0040,
    parameter int unsigned         RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]        state;
    logic [2:0]        lat_cnt;
    logic [ADDR_W-1:0] offset;
    logic              addr_ok;

    // Unsigned subtraction wraps for addresses below base, so the explicit
    // lower-bound compare is what rejects them.
    assign offset  = paddr - ADDR_BASE;
    assign addr_ok = (paddr[1:0] == 2'b00) && (paddr >= ADDR_BASE) && (offset < ADDR_SIZE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a genuine setup phase starts a transfer.
                    if (psel && !penable) begin
                        if (!addr_ok) begin
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            prdata  <= '0;
                            state   <= RESP;
                        end else if (pwrite) begin
                            addr   <= offset;
                            wdata  <= pwdata;
                            wr_en  <= 1'b1;
                            pready <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            addr    <= offset;
                            rd_en   <= 1'b1;
                            lat_cnt <= 3'(RD_LAT);
                            state   <= RD_WAIT;
                        end
                    end
                end
                WRITE: state <= IDLE;
                RD_WAIT: begin
                    // An abort wins over completion so stale data never reaches prdata.
                    if (!psel) begin
                        state <= IDLE;
                    end else if (lat_cnt == 3'd0) begin
                        prdata <= rdata;
                        pready <= 1'b1;
                        state  <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_apb_bridge.sv
// Directed self-checking bench for dma_apb_bridge using three instances with
// different read latencies and base addresses.
module tb_dma_apb_bridge;

    logic        clk;
    logic        rst_n;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] rdata;

    logic [31:0] prdata_o  [3];
    logic        pready_o  [3];
    logic        pslverr_o [3];
    logic        wr_en_o   [3];
    logic        rd_en_o   [3];
    logic [31:0] addr_o    [3];
    logic [31:0] wdata_o   [3];

    int checks = 0;
    int errors = 0;

    dma_apb_bridge #(.ADDR_BASE(32'h0000_0000), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_o[0]), .pready(pready_o[0]),
        .pslverr(pslverr_o[0]), .wr_en(wr_en_o[0]), .rd_en(rd_en_o[0]), .addr(addr_o[0]),
        .wdata(wdata_o[0]), .rdata(rdata));

    dma_apb_bridge #(.ADDR_BASE(32'h0000_0000), .RD_LAT(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_o[1]), .pready(pready_o[1]),
        .pslverr(pslverr_o[1]), .wr_en(wr_en_o[1]), .rd_en(rd_en_o[1]), .addr(addr_o[1]),
        .wdata(wdata_o[1]), .rdata(rdata));

    dma_apb_bridge #(.ADDR_BASE(32'h0000_0100), .RD_LAT(3)) u_base (
        .clk(clk), .rst_n(rst_n), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_o[2]), .pready(pready_o[2]),
        .pslverr(pslverr_o[2]), .wr_en(wr_en_o[2]), .rd_en(rd_en_o[2]), .addr(addr_o[2]),
        .wdata(wdata_o[2]), .rdata(rdata));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic sel, input logic en,
                                 input logic wr, input logic [31:0] a, input logic [31:0] d);
        psel_v      = 3'b000;
        psel_v[idx] = sel;
        penable     = en;
        pwrite      = wr;
        paddr       = a;
        pwdata      = d;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runWrite(input int idx, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_addr);
        applyStimulus(idx, 1'b1, 1'b0, 1'b1, a, d);
        tick();
        penable = 1'b1;
        checkOutput("wr_strobe",  32'(wr_en_o[idx]),   32'd1);
        checkOutput("wr_no_rd",   32'(rd_en_o[idx]),   32'd0);
        checkOutput("wr_pready",  32'(pready_o[idx]),  32'd1);
        checkOutput("wr_pslverr", 32'(pslverr_o[idx]), 32'd0);
        checkOutput("wr_addr",    addr_o[idx],          exp_addr);
        checkOutput("wr_wdata",   wdata_o[idx],         d);
        tick();
        applyStimulus(idx, 1'b0, 1'b0, 1'b0, a, d);
        checkOutput("wr_pready_drop", 32'(pready_o[idx]), 32'd0);
        checkOutput("wr_strobe_drop", 32'(wr_en_o[idx]),  32'd0);
    endtask

    task automatic runRead(input int idx, input logic [31:0] a, input int lat,
                           input logic [31:0] val, input logic [31:0] exp_addr);
        int rd_cnt;
        int ready_at;
        rd_cnt   = 0;
        ready_at = -1;
        applyStimulus(idx, 1'b1, 1'b0, 1'b0, a, 32'h0);
        rdata = 32'h0BAD_0000;
        tick();
        penable = 1'b1;
        checkOutput("rd_addr", addr_o[idx], exp_addr);
        checkOutput("rd_no_wr", 32'(wr_en_o[idx]), 32'd0);
        for (int k = 1; k <= 20 && ready_at < 0; k++) begin
            if (rd_en_o[idx]) rd_cnt++;
            if (pready_o[idx]) ready_at = k;
            rdata = (k == 1 + lat) ? val : (32'h0BAD_0000 | 32'(k));
            if (ready_at < 0) tick();
        end
        checkOutput("rd_pready_cycle", 32'(ready_at), 32'(2 + lat));
        checkOutput("rd_strobe_count", 32'(rd_cnt), 32'd1);
        checkOutput("rd_prdata", prdata_o[idx], val);
        checkOutput("rd_pslverr", 32'(pslverr_o[idx]), 32'd0);
        tick();
        applyStimulus(idx, 1'b0, 1'b0, 1'b0, a, 32'h0);
        checkOutput("rd_pready_drop", 32'(pready_o[idx]), 32'd0);
    endtask

    task automatic runError(input int idx, input logic [31:0] a, input logic wr);
        applyStimulus(idx, 1'b1, 1'b0, wr, a, 32'hFFFF_FFFF);
        tick();
        penable = 1'b1;
        checkOutput("err_pready",  32'(pready_o[idx]),  32'd1);
        checkOutput("err_pslverr", 32'(pslverr_o[idx]), 32'd1);
        checkOutput("err_prdata",  prdata_o[idx],        32'h0);
        checkOutput("err_no_wr",   32'(wr_en_o[idx]),   32'd0);
        checkOutput("err_no_rd",   32'(rd_en_o[idx]),   32'd0);
        tick();
        applyStimulus(idx, 1'b0, 1'b0, 1'b0, a, 32'h0);
        checkOutput("err_pready_drop", 32'(pready_o[idx]), 32'd0);
    endtask

    initial begin
        logic seen_ready;
        rst_n = 1'b0;
        rdata = 32'h0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        checkOutput("rst_prdata",  prdata_o[0],        32'h0);
        checkOutput("rst_pready",  32'(pready_o[0]),  32'd0);
        checkOutput("rst_pslverr", 32'(pslverr_o[0]), 32'd0);
        checkOutput("rst_wr_en",   32'(wr_en_o[0]),   32'd0);
        checkOutput("rst_rd_en",   32'(rd_en_o[0]),   32'd0);
        checkOutput("rst_addr",    addr_o[0],          32'h0);
        checkOutput("rst_wdata",   wdata_o[0],         32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] write and reads");
        runWrite(0, 32'h08, 32'hDEAD_BEEF, 32'h08);
        runRead(0, 32'h08, 1, 32'hCAFE_0001, 32'h08);
        runRead(1, 32'h08, 4, 32'hCAFE_0004, 32'h08);

        // A setup-less access phase in IDLE must be ignored.
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h1111_1111);
        tick();
        checkOutput("ignore_no_wr", 32'(wr_en_o[0]), 32'd0);
        checkOutput("ignore_no_ready", 32'(pready_o[0]), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("[TB] reset during read");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h0);
        tick();
        penable = 1'b1;
        checkOutput("mid_rd_strobe", 32'(rd_en_o[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rd_en",  32'(rd_en_o[1]),  32'd0);
        checkOutput("async_addr",   addr_o[1],         32'h0);
        checkOutput("async_prdata", prdata_o[1],       32'h0);
        checkOutput("async_pready", 32'(pready_o[1]), 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        runRead(1, 32'h3C, 4, 32'h1234_ABCD, 32'h3C);

        $display("[TB] error responses");
        runError(0, 32'h42, 1'b0);
        runError(0, 32'h40, 1'b1);
        runError(2, 32'hFC, 1'b0);

        $display("[TB] abort during read");
        runRead(2, 32'h108, 3, 32'h5A5A_0003, 32'h08);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h10C, 32'h0);
        tick();
        penable = 1'b1;
        checkOutput("abort_rd_strobe", 32'(rd_en_o[2]), 32'd1);
        tick();
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 32'h10C, 32'h0);
        rdata = 32'hBAD0_BAD0;
        seen_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (pready_o[2] !== 1'b0) seen_ready = 1'b1;
        end
        checkOutput("abort_no_pready", 32'(seen_ready), 32'd0);
        checkOutput("abort_prdata", prdata_o[2], 32'h5A5A_0003);
        runWrite(2, 32'h104, 32'h1234_5678, 32'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
